// File: rtl/wavelet_transform_core_if.sv
// ============================================================================
// Module      : wavelet_transform_core_if
// Description : Sample strobe, sample value, channel select and coefficient
//               output bundle for the Haar wavelet engine.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface wavelet_transform_core_if;
    logic       i_data_clk;
    logic [7:0] i_value;
    logic [7:0] i_select_output_channel;
    logic [7:0] o_multiplexed_wavelet_out;
    logic       o_active;

    modport master (
        output i_data_clk,
        output i_value,
        output i_select_output_channel,
        input  o_multiplexed_wavelet_out,
        input  o_active
    );

    modport slave (
        input  i_data_clk,
        input  i_value,
        input  i_select_output_channel,
        output o_multiplexed_wavelet_out,
        output o_active
    );
endinterface

`default_nettype wire

// File: rtl/wavelet_transform_core.sv
// ============================================================================
// Module      : wavelet_transform_core
// Description : Streaming multi-level Haar transform; one coefficient channel
//               is muxed onto a registered 8-bit output with a valid flag.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module wavelet_transform_core #(
    parameter int NUM_LEVELS  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic               clk,
    input  wire logic               reset,
    wavelet_transform_core_if.slave bus
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_q;
    logic [SYNC_STAGES:0]   r_fill;
    logic                   r_armed;
    logic                   w_sync_top;
    logic                   w_edge;
    logic [SYNC_STAGES:0]   w_sync_next;

    logic [7:0]             w_app [0:NUM_LEVELS];
    logic [7:0]             w_det [1:NUM_LEVELS];
    logic [NUM_LEVELS:0]    w_vld;
    logic [NUM_LEVELS-1:0]  w_fire;

    logic [7:0]             r_sample;
    logic                   r_sample_vld;
    logic                   r_sample_new;

    logic [7:0]             w_sel_val;
    logic                   w_sel_vld;
    logic [7:0]             r_out;
    logic                   r_act;

    assign w_sync_next = {r_sync, bus.i_data_clk};
    assign w_sync_top  = r_sync[SYNC_STAGES-1];
    // Arming waits until the chain holds real strobe history and has seen it
    // low, so a strobe already high at reset release is not taken as an edge.
    assign w_edge      = r_armed & w_sync_top & ~r_sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync       <= '0;
            r_sync_q     <= 1'b0;
            r_fill       <= '0;
            r_armed      <= 1'b0;
            r_sample     <= '0;
            r_sample_vld <= 1'b0;
            r_sample_new <= 1'b0;
        end else begin
            r_sync       <= w_sync_next[SYNC_STAGES-1:0];
            r_sync_q     <= w_sync_top;
            r_fill       <= {r_fill[SYNC_STAGES-1:0], 1'b1};
            r_armed      <= r_armed | (r_fill[SYNC_STAGES] & ~w_sync_top);
            r_sample_new <= w_edge;
            if (w_edge) begin
                r_sample     <= bus.i_value;
                r_sample_vld <= 1'b1;
            end
        end
    end

    assign w_app[0]  = r_sample;
    assign w_vld[0]  = r_sample_vld;
    assign w_fire[0] = r_sample_new;

    for (genvar k = 1; k <= NUM_LEVELS; k++) begin : g_level
        logic [7:0] r_first;
        logic       r_phase;
        logic [7:0] r_a;
        logic [7:0] r_d;
        logic       r_v;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_first <= '0;
                r_phase <= 1'b0;
                r_a     <= '0;
                r_d     <= '0;
                r_v     <= 1'b0;
            end else if (w_fire[k-1]) begin
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_first <= w_app[k-1];
                end else begin
                    r_a <= 8'(({1'b0, r_first} + {1'b0, w_app[k-1]}) >> 1);
                    // Bits [8:1] of the 9-bit difference equal the low byte of
                    // its arithmetic right shift.
                    r_d <= 8'(({1'b0, r_first} - {1'b0, w_app[k-1]}) >> 1);
                    r_v <= 1'b1;
                end
            end
        end

        assign w_app[k] = r_a;
        assign w_det[k] = r_d;
        assign w_vld[k] = r_v;

        if (k < NUM_LEVELS) begin : g_fwd
            logic r_fire;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_fire <= 1'b0;
                end else begin
                    r_fire <= w_fire[k-1] & r_phase;
                end
            end

            assign w_fire[k] = r_fire;
        end
    end

    always_comb begin
        w_sel_val = '0;
        w_sel_vld = 1'b0;
        if (bus.i_select_output_channel == 8'd0) begin
            w_sel_val = w_app[0];
            w_sel_vld = w_vld[0];
        end
        for (int k = 1; k <= NUM_LEVELS; k++) begin
            if (bus.i_select_output_channel == 8'(k)) begin
                w_sel_val = w_det[k];
                w_sel_vld = w_vld[k];
            end
            if (bus.i_select_output_channel == 8'(NUM_LEVELS + k)) begin
                w_sel_val = w_app[k];
                w_sel_vld = w_vld[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= '0;
            r_act <= 1'b0;
        end else begin
            r_out <= w_sel_val;
            r_act <= w_sel_vld;
        end
    end

    assign bus.o_multiplexed_wavelet_out = r_out;
    assign bus.o_active                  = r_act;

endmodule

`default_nettype wire

// File: tb/tb_wavelet_transform_core.sv
// ============================================================================
// Module      : tb_wavelet_transform_core
// Description : Scoreboard bench for wavelet_transform_core against a
//               pairwise Haar reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_wavelet_transform_core;
    localparam int N  = 4;
    localparam int SS = 2;

    typedef struct {
        int         sel;
        logic [7:0] val;
        logic       act;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wavelet_transform_core_if bus ();

    wavelet_transform_core #(
        .NUM_LEVELS (N),
        .SYNC_STAGES(SS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sb[$];

    // Reference model: every level keeps a list of pending inputs; two of them
    // form a pair producing an average and a floor-halved difference.
    int m_app [0:N];
    int m_det [1:N];
    bit m_vld [0:N];
    int m_pend[1:N][$];

    function automatic void model_reset();
        for (int k = 0; k <= N; k++) begin
            m_app[k] = 0;
            m_vld[k] = 1'b0;
        end
        for (int k = 1; k <= N; k++) begin
            m_det[k] = 0;
            m_pend[k].delete();
        end
    endfunction

    function automatic void model_push(int v);
        int cur;
        int a;
        int d;
        m_app[0] = v;
        m_vld[0] = 1'b1;
        cur = v;
        for (int k = 1; k <= N; k++) begin
            m_pend[k].push_back(cur);
            if (m_pend[k].size() < 2) break;
            a = m_pend[k].pop_front();
            void'(m_pend[k].pop_front());
            d = a - cur;
            m_app[k] = (a + cur) / 2;
            m_det[k] = (d >= 0) ? d / 2 : -((-d + 1) / 2);
            m_vld[k] = 1'b1;
            cur = m_app[k];
        end
    endfunction

    function automatic exp_t model_expect(int sel);
        exp_t e;
        e.sel = sel;
        e.val = 8'h00;
        e.act = 1'b0;
        if (sel == 0) begin
            e.val = 8'(m_app[0]);
            e.act = m_vld[0];
        end else if (sel >= 1 && sel <= N) begin
            e.val = 8'(m_det[sel] & 255);
            e.act = m_vld[sel];
        end else if (sel > N && sel <= 2 * N) begin
            e.val = 8'(m_app[sel - N]);
            e.act = m_vld[sel - N];
        end
        return e;
    endfunction

    task automatic cmp8(string name, int sel, logic [7:0] act, logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s sel=%0d: got 0x%02h, expected 0x%02h", name, sel, act, req);
        end
    endtask

    // Monitor: compares the registered output against each queued expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp8("coef", e.sel, bus.o_multiplexed_wavelet_out, e.val);
            cmp8("active", e.sel, {7'd0, bus.o_active}, {7'd0, e.act});
        end
    end

    task automatic check_sel(int sel);
        @(negedge clk);
        bus.i_select_output_channel = 8'(sel);
        @(posedge clk);
        @(posedge clk);
        sb.push_back(model_expect(sel));
        @(negedge clk);
    endtask

    task automatic check_all();
        for (int s = 0; s <= 2 * N + 1; s++) check_sel(s);
        check_sel($urandom_range(255, 2 * N + 1));
    endtask

    task automatic send(int v);
        @(negedge clk);
        bus.i_value = 8'(v);
        repeat (3) @(negedge clk);
        bus.i_data_clk = 1'b1;
        model_push(v);
        repeat (8) @(negedge clk);
        bus.i_data_clk = 1'b0;
        repeat (2 * N + 4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        cmp8("async_rst_out", -1, bus.o_multiplexed_wavelet_out, 8'h00);
        cmp8("async_rst_act", -1, {7'd0, bus.o_active}, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic run_seq(int vals[$]);
        do_reset();
        foreach (vals[i]) begin
            send(vals[i]);
            check_all();
        end
    endtask

    initial begin
        int q[$];
        bus.i_data_clk              = 1'b0;
        bus.i_value                 = 8'd0;
        bus.i_select_output_channel = 8'd0;
        model_reset();

        // Held in reset: output stays clear for any select.
        repeat (3) @(negedge clk);
        check_sel(0);
        check_sel(9);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check_sel(0);

        q = '{10, 20};                 run_seq(q);
        q = '{10, 20, 30, 50};         run_seq(q);
        q = '{0, 255};                 run_seq(q);
        q = '{255, 255};               run_seq(q);
        q = '{255, 0};                 run_seq(q);
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(100);
        run_seq(q);

        // A stored first value must not survive a reset pulse.
        q = '{10};                     run_seq(q);
        do_reset();
        send(30); send(50);
        check_all();
        check_sel(200);

        q.delete();
        for (int i = 0; i < 24; i++) q.push_back(int'($urandom_range(255, 0)));
        run_seq(q);

        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/wavelet_transform_core.md
Name: wavelet_transform_core

Overview:
Streaming multi-level Haar wavelet transform engine in the user project area. It receives 8-bit samples from GPIO, each qualified by a slow external strobe (i_data_clk). It computes approximation and detail coefficients for NUM_LEVELS cascaded levels. One selected coefficient channel is presented on an 8-bit output bus, with a valid flag.

Parameters:
NUM_LEVELS, 4, number of cascaded Haar levels (channels scale with it)
SYNC_STAGES, 2, flip-flops in the i_data_clk synchronizer

Ports:
clk  input  1  system clock (Wishbone clock)
reset  input  1  asynchronous, active-high reset
i_data_clk  input  1  external sample strobe, asynchronous to clk; a sample is taken on each rising edge
i_value  input  8  unsigned input sample
i_select_output_channel  input  8  channel select for output mux
o_multiplexed_wavelet_out  output  8  selected coefficient, registered
o_active  output  1  high when the selected channel holds a valid value

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high. All state clears immediately on reset assertion.
- Reset values:
  - all outputs 0;
  - all coefficient registers 0;
  - all valid flags 0;
  - all pair-phase bits 0 (expecting the first sample of a pair);
  - synchronizer flops 0.
- Strobe handling:
  - i_data_clk passes through a SYNC_STAGES flop synchronizer, then a rising-edge detector (prior-stage 0, current-stage 1).
  - Let E be the clk cycle in which the edge is detected.
  - i_value is captured at E into sample register S (channel 0); S_valid is set.
  - i_value must be stable from 3 clk cycles before the i_data_clk rise until 1 cycle after E.
- Level k (k=1..NUM_LEVELS):
  - Input stream is S for k=1, otherwise the level k-1 approximation.
  - Each new input toggles the phase bit.
  - Phase 0: store the value as "first" (a).
  - Phase 1 (value b):
    - A_k = (a+b)>>1, computed in 9 bits, unsigned result.
    - D_k = (a-b)>>>1, computed in 9-bit signed, two's-complement 8-bit result (range -128..127).
    - The valid flag of the level sets.
  - A new A_k feeds level k+1 as a new input in the following cycle.
- Latency:
  - S updates at E+1.
  - A_k/D_k update at E+1+k (only on completing pairs).
  - o_multiplexed_wavelet_out reflects a change one cycle later (E+2+k).
- Channel map:
  - 0 = S;
  - 1..NUM_LEVELS = D_1..D_N;
  - NUM_LEVELS+1..2*NUM_LEVELS = A_1..A_N;
  - any other select gives output 0 and o_active 0.
- Output register:
  - Each clk, o_multiplexed_wavelet_out <= selected coefficient.
  - o_active <= valid flag of the selected channel.
  - A select change takes effect next clk.
- Coefficients hold their last value until overwritten; no wrap or overflow beyond the stated arithmetic.
- Strobe edges closer than 2*NUM_LEVELS+2 clk cycles apart are unsupported.
- A held-high i_data_clk produces only one sample; a level-high strobe after reset release does not sample.
- Reset mid-pair discards the stored "first" values; the pair after reset starts fresh.

Test Plan:
- Reset, select=0, no strobes -> output 0x00, o_active 0. Select 9 with reset asserted -> output 0, o_active 0.
- Samples 10, 20; select 0 -> 0x14 (o_active 1). Select 1 (D_1) -> 0xFB (-5). Select 5 (A_1) -> 0x0F (15).
- Samples 10, 20, 30, 50:
  - D_1 -> 0xF6 (-10); A_1 -> 40 (0x28).
  - A_2 (select 6) -> 27 (0x1B); D_2 (select 2) -> 0xF3 (-13).
  - A_3 (select 7) still o_active 0.
- Boundaries:
  - 0, 255 -> D_1 = 0x80 (-128), A_1 = 0x7F.
  - 255, 255 -> A_1 = 0xFF, D_1 = 0x00.
  - 255, 0 -> D_1 = 0x7F.
- Eight samples all 100 -> A_1, A_2, A_3 = 100 and D_1, D_2, D_3 = 0. After 16 samples, A_4 = 100 and o_active 1 on select 8.
- Sample 10, then reset pulse, then samples 30, 50 -> A_1 = 40, not mixing with 10. Select 200 -> output 0, o_active 0.
